// File: rtl/writeback_if.sv
// Bundle of issue, result-offer and register-file write signals for the writeback unit.
// The master side is the core pipeline that drives it, and the slave side is writeback_unit.
interface writeback_if;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_ready;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [63:0] ld_data;
  logic        ld_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [63:0] rf_write_data;
  logic [31:0] pending;
  logic [2:0]  ld_count;
  logic        wb_error;

  modport master (
    output issue_valid, issue_addr, alu_valid, alu_addr, alu_data,
           ld_valid, ld_addr, ld_data,
    input  issue_ready, alu_ready, ld_ready, rf_write_enable, rf_write_addr,
           rf_write_data, pending, ld_count, wb_error
  );

  modport slave (
    input  issue_valid, issue_addr, alu_valid, alu_addr, alu_data,
           ld_valid, ld_addr, ld_data,
    output issue_ready, alu_ready, ld_ready, rf_write_enable, rf_write_addr,
           rf_write_data, pending, ld_count, wb_error
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback arbiter: it reserves destinations in a scoreboard and merges ALU results with a 4-deep load FIFO.
// It emits one registered register-file write per cycle.
module writeback_unit (
  input  logic       clk,
  input  logic       rst,
  writeback_if.slave wb
);
  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } entry_t;

  entry_t      fifo_q [4];
  entry_t      fifo_d [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] pending_q, pending_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;

  logic full;
  logic issue_fire;
  logic alu_fire;
  logic ld_fire;
  logic ld_pop;

  assign full           = (count_q == 3'd4);
  assign wb.issue_ready = ~pending_q[wb.issue_addr];
  assign wb.alu_ready   = ~full;
  assign wb.ld_ready    = ~full;

  assign wb.rf_write_enable = wr_en_q;
  assign wb.rf_write_addr   = wr_addr_q;
  assign wb.rf_write_data   = wr_data_q;
  assign wb.pending         = pending_q;
  assign wb.ld_count        = count_q;
  assign wb.wb_error        = err_q;

  // A full queue blocks the ALU, so the head drains before any new ALU result is taken.
  always_comb begin
    issue_fire = wb.issue_valid & ~pending_q[wb.issue_addr];
    alu_fire   = wb.alu_valid & ~full;
    ld_fire    = wb.ld_valid & ~full;
    ld_pop     = ~alu_fire & (count_q != 3'd0);

    fifo_d    = fifo_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    pending_d = pending_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (alu_fire) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wb.alu_addr;
      wr_data_d = wb.alu_data;
    end else if (ld_pop) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fifo_q[rd_ptr_q].addr;
      wr_data_d = fifo_q[rd_ptr_q].data;
      rd_ptr_d  = rd_ptr_q + 2'd1;
    end

    if (issue_fire)
      pending_d[wb.issue_addr] = 1'b1;
    if (wr_en_d) begin
      if (!pending_q[wr_addr_d])
        err_d = 1'b1;
      pending_d[wr_addr_d] = 1'b0;
    end

    if (ld_fire) begin
      fifo_d[wr_ptr_q].addr = wb.ld_addr;
      fifo_d[wr_ptr_q].data = wb.ld_data;
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end

    count_d = count_q + {2'b00, ld_fire} - {2'b00, ld_pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        fifo_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      fifo_q    <= fifo_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenarios and a randomized run of writeback_unit.
// A queue-based scoreboard model supplies every expected value.
module tb_writeback_unit;
  logic clk;
  logic rst;
  writeback_if bus ();

  writeback_unit dut (.clk(clk), .rst(rst), .wb(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ment_t;

  ment_t       m_q [$];
  logic [31:0] m_pend;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  logic        m_err;
  int          compared;
  int          mismatched;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check readies, advance model, check registered state after posedge.
  task automatic applyStimulus(input logic r, input logic iv, input logic [4:0] ia,
                               input logic av, input logic [4:0] aa, input logic [63:0] ad,
                               input logic lv, input logic [4:0] la, input logic [63:0] ldd);
    logic        full, a_fire, pop, wr, iv_eff, i_fire;
    logic [4:0]  w_a;
    logic [63:0] w_d;
    full   = (m_q.size() == 4);
    a_fire = av && !full;
    pop    = !a_fire && (m_q.size() > 0);
    wr     = a_fire || pop;
    w_a    = a_fire ? aa : (pop ? m_q[0].a : 5'd0);
    w_d    = a_fire ? ad : (pop ? m_q[0].d : 64'd0);
    iv_eff = iv;
    if (iv && !m_pend[ia] && wr && (w_a == ia))
      iv_eff = 1'b0;
    i_fire = iv_eff && !m_pend[ia];

    @(negedge clk);
    rst             = r;
    bus.issue_valid = iv_eff;
    bus.issue_addr  = ia;
    bus.alu_valid   = av;
    bus.alu_addr    = aa;
    bus.alu_data    = ad;
    bus.ld_valid    = lv;
    bus.ld_addr     = la;
    bus.ld_data     = ldd;
    #1;
    checkOutput("issue_ready", {63'd0, bus.issue_ready}, {63'd0, !m_pend[ia]});
    checkOutput("alu_ready", {63'd0, bus.alu_ready}, {63'd0, !full});
    checkOutput("ld_ready", {63'd0, bus.ld_ready}, {63'd0, !full});

    if (!r) begin
      m_q.delete();
      m_pend = '0;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_err  = 1'b0;
    end else begin
      m_en = wr;
      if (wr) begin
        m_addr = w_a;
        m_data = w_d;
        if (!m_pend[w_a]) m_err = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (i_fire) m_pend[ia] = 1'b1;
      if (wr) m_pend[w_a] = 1'b0;
      if (lv && !full) m_q.push_back('{a: la, d: ldd});
    end

    @(posedge clk);
    #1;
    checkOutput("rf_write_enable", {63'd0, bus.rf_write_enable}, {63'd0, m_en});
    checkOutput("rf_write_addr", {59'd0, bus.rf_write_addr}, {59'd0, m_addr});
    checkOutput("rf_write_data", bus.rf_write_data, m_data);
    checkOutput("pending", {32'd0, bus.pending}, {32'd0, m_pend});
    checkOutput("ld_count", {61'd0, bus.ld_count}, 64'(m_q.size()));
    checkOutput("wb_error", {63'd0, bus.wb_error}, {63'd0, m_err});
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1, 5'd3, 1'b1, 5'd3, 64'hdead, 1'b1, 5'd2, 64'hbeef);
  endtask

  task automatic issue(input logic [4:0] a);
    applyStimulus(1'b1, 1'b1, a, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_pend = '0; m_en = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
    rst = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_addr = '0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;

    doReset();
    doReset();
    checkOutput("reset_pending", {32'd0, bus.pending}, 64'd0);
    checkOutput("reset_wr_en", {63'd0, bus.rf_write_enable}, 64'd0);
    idle();

    // Issue r5, then the ALU returns r5.
    issue(5'd5);
    checkOutput("r5_reserved", {63'd0, bus.pending[5]}, 64'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
    checkOutput("r5_addr", {59'd0, bus.rf_write_addr}, 64'd5);
    checkOutput("r5_data", bus.rf_write_data, 64'h1234);
    checkOutput("r5_cleared", {63'd0, bus.pending[5]}, 64'd0);

    // Issuing r7 twice back-to-back: the second issue is refused until r7 is written.
    issue(5'd7);
    issue(5'd7);
    checkOutput("r7_refused", {63'd0, bus.issue_ready}, 64'd0);
    checkOutput("r7_still_pending", {63'd0, bus.pending[7]}, 64'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0);

    // Five loads while the ALU is busy: the queue fills, then the head drains in order.
    for (int k = 1; k <= 5; k++) issue(5'(k));
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'(10 + k), 64'(k), 1'b1, 5'(k), 64'(100 + k));
    checkOutput("ld_full_count", {61'd0, bus.ld_count}, 64'd4);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd15, 64'd5, 1'b1, 5'd5, 64'd105);
    checkOutput("ld_head_first", {59'd0, bus.rf_write_addr}, 64'd1);
    for (int k = 2; k <= 4; k++) begin
      idle();
      checkOutput("ld_order", {59'd0, bus.rf_write_addr}, 64'(k));
    end

    // An ALU result and a load arrive on the same edge with the queue empty.
    doReset();
    issue(5'd3);
    issue(5'd4);
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    checkOutput("same_edge_alu", {59'd0, bus.rf_write_addr}, 64'd3);
    checkOutput("same_edge_count1", {61'd0, bus.ld_count}, 64'd1);
    idle();
    checkOutput("same_edge_ld", {59'd0, bus.rf_write_addr}, 64'd4);
    checkOutput("same_edge_count0", {61'd0, bus.ld_count}, 64'd0);

    // A write to a register that was never reserved sets a sticky error.
    applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd9, 64'h9999, 1'b0, 5'd0, 64'd0);
    checkOutput("err_write_data", bus.rf_write_data, 64'h9999);
    checkOutput("err_set", {63'd0, bus.wb_error}, 64'd1);
    idle(); idle();
    checkOutput("err_sticky", {63'd0, bus.wb_error}, 64'd1);

    // A reset arrives with queued loads and outstanding reservations.
    for (int k = 4; k <= 7; k++) issue(5'(k));
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 64'd0, 1'b1, 5'(20 + k), 64'(k));
    checkOutput("pre_rst_pending", {32'd0, bus.pending}, 64'h0000_00F0);
    checkOutput("pre_rst_count", {61'd0, bus.ld_count}, 64'd3);
    doReset();
    checkOutput("rst_count", {61'd0, bus.ld_count}, 64'd0);
    checkOutput("rst_err", {63'd0, bus.wb_error}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      idle();
      checkOutput("no_stale_write", {63'd0, bus.rf_write_enable}, 64'd0);
    end

    // Randomized traffic over a narrow register range so that collisions are frequent.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 79) != 0),
                    1'($urandom), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have a single clock, clk; reset is synchronous and active-low, named rst (sampled on posedge clk only).
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  synchronous active-low reset.
REQ-004 SHALL have port: issue_valid  input  1  decode requests destination reservation.
REQ-005 SHALL have port: issue_addr  input  5  destination register to reserve.
REQ-006 SHALL have port: issue_ready  output  1  reservation accepted this cycle.
REQ-007 SHALL have port: alu_valid / alu_addr / alu_data  input  1/5/64  ALU result offer.
REQ-008 SHALL have port: alu_ready  output  1  ALU result accepted this cycle.
REQ-009 SHALL have port: ld_valid / ld_addr / ld_data  input  1/5/64  load result offer.
REQ-010 SHALL have port: ld_ready  output  1  load result accepted into queue this cycle.
REQ-011 SHALL have port: rf_write_enable / rf_write_addr / rf_write_data  output  1/5/64  registered register-file write port.
REQ-012 SHALL have port: pending  output  32  scoreboard; bit i set = register i awaiting writeback.
REQ-013 SHALL have port: ld_count  output  3  load-queue occupancy, 0..4.
REQ-014 SHALL have port: wb_error  output  1  sticky; writeback to non-pending register seen.

Function
REQ-015 SHALL accept a transfer on any port only in a cycle where valid and ready are both 1 at posedge clk.
REQ-016 SHALL drive issue_ready = issue_valid-independent !pending[issue_addr], using pending as registered (before any same-cycle clear).
REQ-017 SHALL set pending[issue_addr] on the posedge following issue handshake.
REQ-018 SHALL hold a 4-entry FIFO for load results; ld_ready = (ld_count != 4); no bypass of a full queue.
REQ-019 SHALL select one write per cycle: ALU result has priority unless ld_count == 4, in which case the FIFO head has priority and alu_ready = 0.
REQ-020 SHALL drive alu_ready = 1 whenever ld_count != 4.
REQ-021 SHALL dequeue the FIFO head only in a cycle where it is selected (FIFO non-empty and no accepted ALU transfer).
REQ-022 SHALL register the selected write: rf_write_enable = 1, addr/data of the selected result, on the posedge after selection; rf_write_enable = 0 in cycles with nothing selected (addr/data hold last value).
REQ-023 SHALL give latency: ALU handshake at edge N -> write visible after edge N; load enqueued at edge N -> earliest write visible after edge N+1.
REQ-024 SHALL clear pending[addr] on the same edge the write is registered out.
REQ-025 SHALL let clear win over set is impossible by construction (REQ-016); if set and clear target different registers on one edge, both SHALL take effect.
REQ-026 SHALL allow simultaneous enqueue and dequeue when ld_count is 1..3; ld_count unchanged.
REQ-027 SHALL perform the write even when pending[addr] = 0, and SHALL set wb_error on that edge; wb_error clears only on reset.
REQ-028 SHALL treat register 0 like any other register (no hardwired zero).
REQ-029 SHALL preserve FIFO order; FIFO pointers wrap modulo 4.

Reset
REQ-030 SHALL, on a posedge with rst = 0: pending = 0, FIFO emptied (ld_count = 0), rf_write_enable = 0, rf_write_addr = 0, rf_write_data = 0, wb_error = 0.
REQ-031 SHALL discard all queued load results and ignore any handshake in a reset cycle; no write is emitted after the reset edge.
REQ-032 SHALL drive issue_ready = 1, alu_ready = 1, ld_ready = 1 in the first cycle after reset release.

Verification
REQ-033 Issue r5, then ALU r5 = 0x1234 -> rf_write_enable=1, addr 5, data 0x1234 after the next edge; pending[5] 1 -> 0 on that edge.
REQ-034 Issue r7 twice back-to-back -> second issue_ready = 0 until r7 is written back; pending[7] stays 1.
REQ-035 Five loads r1..r5 with alu_valid held high -> ld_ready = 0 after 4 enqueues; ld_count = 4; next cycle alu_ready = 0 and r1 written first; writes r1..r4 in order.
REQ-036 Same-edge ALU r3 and load r4 with empty FIFO -> r3 written first, r4 next cycle; ld_count 1 -> 0.
REQ-037 ALU write to r9 with pending[9] = 0 -> write emitted with data; wb_error = 1 and stays 1 until rst.
REQ-038 Assert rst with 3 queued loads and pending = 0x0000_00F0 -> after edge: ld_count = 0, pending = 0, rf_write_enable = 0; no queued load ever written.
